mqam_upsampler: RTL and testbench
=================================

Name: mqam_upsampler

Overview:
- Parametrised successor to the fixed 16-QAM mapper plus 4x upsampler pair in the transmit chain.
- Maps a symbol word to square M-QAM I/Q levels using per-axis Gray coding, then upsamples both rails by UPSAMPLE.
- Run-time selectable zero-stuff (impulse) or sample-hold output mode.
- Counts symbol underflows and emits a per-symbol strobe for scope and DAC alignment. Sits between the LFSR data source and the pulse-shaping filters, clocked on sys_clk with the clk_gen enables.

Parameters:
- ORDER_LOG2, 4, bits per symbol; legal values 2, 4, 6 (4/16/64-QAM); K = 2^(ORDER_LOG2/2) levels per axis.
- UPSAMPLE, 4, samples per symbol; integer 2..16.
- AMP, 16384, level step A in 1s17; elaboration error unless (K-1)*AMP <= 131071.
- CNT_W, 16, underflow counter width.

Ports:
- clk, in, 1, system clock (sys_clk).
- reset, in, 1, asynchronous active-low reset.
- sym_clk_en, in, 1, symbol-rate enable.
- sam_clk_en, in, 1, sample-rate enable.
- data, in, ORDER_LOG2, symbol word. Upper half drives I, lower half drives Q.
- data_valid, in, 1, data is valid; sampled only when sym_clk_en=1.
- hold_mode, in, 1, 0 = zero-stuff, 1 = sample-hold; sampled on sam_clk_en.
- out_i, out, 18, signed 1s17 in-phase sample.
- out_q, out, 18, signed 1s17 quadrature sample.
- sym_strobe, out, 1, one-clk pulse when the phase-0 sample is written.
- phase, out, 4, current sample index within the symbol.
- underflow_cnt, out, CNT_W, number of symbols with data_valid=0.

Behaviour:
- Reset (reset=0, asynchronous): out_i, out_q, sym_i, sym_q, phase, underflow_cnt and sym_strobe all go to 0. Release is synchronous to clk.
- Mapping, per axis:
  - The g-bit field (g = ORDER_LOG2/2) is Gray-decoded to index L.
  - Level = (2L-(K-1))*AMP. Computation is done at 18 bits signed and cannot overflow, by the parameter constraint above.
  - 16-QAM Gray order: 00->L0, 01->L1, 11->L2, 10->L3.
- Symbol load, on a cycle with sym_clk_en=1:
  - If data_valid=1: sym_i/sym_q <= mapped levels.
  - If data_valid=0: sym_i/sym_q <= 0, and underflow_cnt increments, saturating at all-ones.
  - Phase is cleared to 0 the same cycle. This realigns the phase even if it has not reached UPSAMPLE-1.
- Sample update, on a cycle with sam_clk_en=1 and sym_clk_en=0:
  - Output: if phase==0, or hold_mode=1, then out_i/out_q <= sym_i/sym_q; otherwise out_i/out_q <= 0.
  - sym_strobe <= (phase==0).
  - phase <= phase+1, wrapping to 0 after UPSAMPLE-1. Free-running wrap covers a missing sym_clk_en.
- Coincident enables (sam_clk_en=1 and sym_clk_en=1, the normal clk_gen alignment):
  - Symbol load takes priority.
  - Outputs hold their values and sym_strobe=0.
  - The new symbol appears at the next sam_clk_en, with phase 0.
- Latency: a symbol sampled at cycle t reaches out_i/out_q on the first sam_clk_en after t, at phase 0. With clk_gen (sam every 4 clk, sym every 16) this is t+4.
- Outputs hold between sample enables. sym_strobe is 0 on every cycle without a sample update.
- hold_mode changes take effect at the next sample update; there is no glitch mid-symbol.
- ORDER_LOG2=2 degenerates to QPSK: levels ±AMP.
- phase width is fixed at 4 bits. Bits above ceil(log2(UPSAMPLE)) read 0.

Test Plan:
- Reset mid-stream: drive reset=0 asynchronously between enables -> out_i, out_q, phase, underflow_cnt and sym_strobe are 0 immediately. The first symbol after release appears at phase 0 with no stale value.
- Mapping, defaults: data=4'b0000 -> out_i=out_q=-49152. data=4'b1001 -> out_i=+49152, out_q=-16384. data=4'b1111 -> out_i=out_q=+16384.
- Zero-stuff, UPSAMPLE=4, hold_mode=0, data=4'b1010: the four samples of the symbol are out_i = 49152, 0, 0, 0, with sym_strobe high only on the first.
- Hold mode, same stimulus with hold_mode=1: out_i=49152 for all four samples. Toggling hold_mode mid-symbol changes only the following samples.
- Underflow: hold data_valid=0 for 3 symbols -> underflow_cnt=3 and outputs 0 for those symbols. With CNT_W=2, 5 underflows -> counter saturates at 3.
- ORDER_LOG2=6, AMP=16384: data=6'b100100 (I field 100 -> L7, Q field 100 -> L7) -> out_i=out_q=+114688. Separately, dropping one sym_clk_en -> phase wraps 0..3 and then realigns at the next sym_clk_en.

Source files
------------

// File: rtl/mqam_upsampler.sv
`default_nettype none
// ============================================================================
// mqam_upsampler : square M-QAM Gray mapper with zero-stuff / sample-hold
//                  upsampling, underflow counting and symbol strobe.
// Revision 1.0 - initial release
// ============================================================================
module mqam_upsampler #(
    parameter int ORDER_LOG2 = 4,
    parameter int UPSAMPLE   = 4,
    parameter int AMP        = 16384,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sym_clk_en,
    input  logic                    sam_clk_en,
    input  logic [ORDER_LOG2-1:0]   data,
    input  logic                    data_valid,
    input  logic                    hold_mode,
    output logic signed [17:0]      out_i,
    output logic signed [17:0]      out_q,
    output logic                    sym_strobe,
    output logic [3:0]              phase,
    output logic [CNT_W-1:0]        underflow_cnt
);

    localparam int G = ORDER_LOG2 / 2;
    localparam int K = 1 << G;
    localparam logic [3:0] LAST_PHASE = 4'(UPSAMPLE - 1);

    generate
        if (!(ORDER_LOG2 == 2 || ORDER_LOG2 == 4 || ORDER_LOG2 == 6)) begin : g_bad_order
            $error("mqam_upsampler: ORDER_LOG2 must be 2, 4 or 6");
        end
        if (UPSAMPLE < 2 || UPSAMPLE > 16) begin : g_bad_upsample
            $error("mqam_upsampler: UPSAMPLE must be in 2..16");
        end
        if ((K - 1) * AMP > 131071) begin : g_bad_amp
            $error("mqam_upsampler: (K-1)*AMP exceeds the 1s17 range");
        end
    endgenerate

    // Gray-decode the axis field to index L, then scale to (2L-(K-1))*AMP.
    function automatic logic signed [17:0] map_level(input logic [G-1:0] gray);
        logic [G-1:0]       bin;
        logic signed [31:0] lvl;
        bin[G-1] = gray[G-1];
        for (int i = G - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        lvl = (2 * $signed({{(32-G){1'b0}}, bin}) - (K - 1)) * AMP;
        return lvl[17:0];
    endfunction

    logic signed [17:0] map_i;
    logic signed [17:0] map_q;
    logic signed [17:0] sym_i;
    logic signed [17:0] sym_q;
    logic               at_phase0;

    assign map_i     = map_level(data[ORDER_LOG2-1:G]);
    assign map_q     = map_level(data[G-1:0]);
    assign at_phase0 = (phase == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym_i         <= '0;
            sym_q         <= '0;
            out_i         <= '0;
            out_q         <= '0;
            phase         <= '0;
            sym_strobe    <= 1'b0;
            underflow_cnt <= '0;
        end else if (sym_clk_en) begin
            // Symbol load wins over a coincident sample enable; outputs hold.
            sym_strobe <= 1'b0;
            phase      <= '0;
            if (data_valid) begin
                sym_i <= map_i;
                sym_q <= map_q;
            end else begin
                sym_i <= '0;
                sym_q <= '0;
                if (underflow_cnt != {CNT_W{1'b1}}) begin
                    underflow_cnt <= underflow_cnt + 1'b1;
                end
            end
        end else if (sam_clk_en) begin
            sym_strobe <= at_phase0;
            if (at_phase0 || hold_mode) begin
                out_i <= sym_i;
                out_q <= sym_q;
            end else begin
                out_i <= '0;
                out_q <= '0;
            end
            // Free-running wrap keeps the sample cadence if a symbol enable is lost.
            if (phase == LAST_PHASE) begin
                phase <= '0;
            end else begin
                phase <= phase + 4'd1;
            end
        end else begin
            sym_strobe <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mqam_upsampler.sv
`default_nettype none
// ============================================================================
// tb_mqam_upsampler : directed self-checking bench for mqam_upsampler.
// Revision 1.0 - initial release
// ============================================================================
module tb_mqam_upsampler;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               sym_clk_en = 1'b0;
    logic               sam_clk_en = 1'b0;
    logic [3:0]         data = 4'b0000;
    logic [5:0]         data6 = 6'b000000;
    logic               data_valid = 1'b0;
    logic               hold_mode = 1'b0;

    logic signed [17:0] out_i0, out_q0, out_i1, out_q1, out_i2, out_q2;
    logic               strobe0, strobe1, strobe2;
    logic [3:0]         phase0, phase1, phase2;
    logic [15:0]        cnt0;
    logic [1:0]         cnt1;
    logic [15:0]        cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mqam_upsampler dut0 (
        .clk(clk), .reset(reset), .sym_clk_en(sym_clk_en), .sam_clk_en(sam_clk_en),
        .data(data), .data_valid(data_valid), .hold_mode(hold_mode),
        .out_i(out_i0), .out_q(out_q0), .sym_strobe(strobe0), .phase(phase0),
        .underflow_cnt(cnt0)
    );

    mqam_upsampler #(.CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .sym_clk_en(sym_clk_en), .sam_clk_en(sam_clk_en),
        .data(data), .data_valid(data_valid), .hold_mode(hold_mode),
        .out_i(out_i1), .out_q(out_q1), .sym_strobe(strobe1), .phase(phase1),
        .underflow_cnt(cnt1)
    );

    mqam_upsampler #(.ORDER_LOG2(6)) dut2 (
        .clk(clk), .reset(reset), .sym_clk_en(sym_clk_en), .sam_clk_en(sam_clk_en),
        .data(data6), .data_valid(data_valid), .hold_mode(hold_mode),
        .out_i(out_i2), .out_q(out_q2), .sym_strobe(strobe2), .phase(phase2),
        .underflow_cnt(cnt2)
    );

    task automatic tick(input logic sy, input logic sa);
        sym_clk_en = sy;
        sam_clk_en = sa;
        @(posedge clk);
        #1;
        sym_clk_en = 1'b0;
        sam_clk_en = 1'b0;
    endtask

    task automatic load(input logic [3:0] d, input logic [5:0] d6, input logic v);
        data       = d;
        data6      = d6;
        data_valid = v;
        tick(1'b1, 1'b1);
    endtask

    task automatic sample();
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (out_i0 !== 18'sd0 || out_q0 !== 18'sd0 || phase0 !== 4'd0 ||
            strobe0 !== 1'b0 || cnt0 !== 16'd0) begin
            fails++;
            $display("FAIL reset_state: i=%0d q=%0d ph=%0d stb=%0b cnt=%0d, want all 0",
                     out_i0, out_q0, phase0, strobe0, cnt0);
        end
        tick(1'b0, 1'b0);
        reset = 1'b1;
        tick(1'b0, 1'b0);
        tests++;
        if (out_i2 !== 18'sd0 || phase2 !== 4'd0 || cnt1 !== 2'd0) begin
            fails++;
            $display("FAIL reset_release: i2=%0d ph2=%0d cnt1=%0d, want 0", out_i2, phase2, cnt1);
        end
    endtask

    task automatic test_mapping();
        logic [3:0] vec [3];
        int         exp_i [3];
        int         exp_q [3];
        vec   = '{4'b0000, 4'b1001, 4'b1111};
        exp_i = '{-49152, 49152, 16384};
        exp_q = '{-49152, -16384, 16384};
        hold_mode = 1'b0;
        for (int n = 0; n < 3; n++) begin
            load(vec[n], 6'b000000, 1'b1);
            sample();
            tests++;
            if (out_i0 !== 18'(exp_i[n]) || out_q0 !== 18'(exp_q[n])) begin
                fails++;
                $display("FAIL map_%b: i=%0d q=%0d, want i=%0d q=%0d",
                         vec[n], out_i0, out_q0, exp_i[n], exp_q[n]);
            end
        end
    endtask

    task automatic test_zero_stuff();
        int exp_i [4];
        exp_i = '{49152, 0, 0, 0};
        hold_mode = 1'b0;
        load(4'b1010, 6'b000000, 1'b1);
        tests++;
        if (strobe0 !== 1'b0 || phase0 !== 4'd0 || out_i0 !== 18'sd16384) begin
            fails++;
            $display("FAIL coincident_load: stb=%0b ph=%0d i=%0d, want 0 0 16384",
                     strobe0, phase0, out_i0);
        end
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b0);
            if (k > 0) begin
                tests++;
                if (strobe0 !== 1'b0 || out_i0 !== 18'(exp_i[k-1])) begin
                    fails++;
                    $display("FAIL zs_between_%0d: stb=%0b i=%0d, want 0 %0d",
                             k, strobe0, out_i0, exp_i[k-1]);
                end
            end
            tick(1'b0, 1'b1);
            tests++;
            if (out_i0 !== 18'(exp_i[k]) || out_q0 !== 18'(exp_i[k]) ||
                strobe0 !== (k == 0) || phase0 !== 4'((k + 1) % 4)) begin
                fails++;
                $display("FAIL zs_sample_%0d: i=%0d q=%0d stb=%0b ph=%0d, want %0d %0d %0b %0d",
                         k, out_i0, out_q0, strobe0, phase0, exp_i[k], exp_i[k],
                         (k == 0), (k + 1) % 4);
            end
        end
    endtask

    task automatic test_hold();
        int exp_i [4];
        hold_mode = 1'b1;
        load(4'b1010, 6'b000000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            sample();
            tests++;
            if (out_i0 !== 18'sd49152 || strobe0 !== (k == 0)) begin
                fails++;
                $display("FAIL hold_sample_%0d: i=%0d stb=%0b, want 49152 %0b",
                         k, out_i0, strobe0, (k == 0));
            end
        end
        exp_i = '{49152, 49152, 0, 0};
        load(4'b1010, 6'b000000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            hold_mode = (k < 2);
            sample();
            tests++;
            if (out_i0 !== 18'(exp_i[k])) begin
                fails++;
                $display("FAIL hold_toggle_%0d: i=%0d, want %0d", k, out_i0, exp_i[k]);
            end
        end
    endtask

    task automatic test_order6();
        hold_mode = 1'b0;
        load(4'b0000, 6'b100100, 1'b1);
        sample();
        tests++;
        if (out_i2 !== 18'sd114688 || out_q2 !== 18'sd114688 || strobe2 !== 1'b1) begin
            fails++;
            $display("FAIL order6_map: i=%0d q=%0d stb=%0b, want 114688 114688 1",
                     out_i2, out_q2, strobe2);
        end
        load(4'b0000, 6'b000001, 1'b1);
        sample();
        tests++;
        if (out_i2 !== -18'sd114688 || out_q2 !== -18'sd81920) begin
            fails++;
            $display("FAIL order6_low: i=%0d q=%0d, want -114688 -81920", out_i2, out_q2);
        end
    endtask

    task automatic test_missing_sym();
        hold_mode = 1'b0;
        load(4'b1111, 6'b000000, 1'b1);
        for (int k = 0; k < 8; k++) begin
            sample();
            tests++;
            if (phase0 !== 4'((k + 1) % 4) || strobe0 !== (k % 4 == 0) ||
                out_i0 !== ((k % 4 == 0) ? 18'sd16384 : 18'sd0)) begin
                fails++;
                $display("FAIL wrap_%0d: ph=%0d stb=%0b i=%0d, want %0d %0b %0d",
                         k, phase0, strobe0, out_i0, (k + 1) % 4, (k % 4 == 0),
                         (k % 4 == 0) ? 16384 : 0);
            end
        end
        hold_mode = 1'b1;
        sample();
        sample();
        load(4'b0000, 6'b000000, 1'b1);
        tests++;
        if (phase0 !== 4'd0 || out_i0 !== 18'sd16384 || strobe0 !== 1'b0) begin
            fails++;
            $display("FAIL realign_load: ph=%0d i=%0d stb=%0b, want 0 16384 0",
                     phase0, out_i0, strobe0);
        end
        sample();
        tests++;
        if (phase0 !== 4'd1 || out_i0 !== -18'sd49152 || strobe0 !== 1'b1) begin
            fails++;
            $display("FAIL realign_sample: ph=%0d i=%0d stb=%0b, want 1 -49152 1",
                     phase0, out_i0, strobe0);
        end
    endtask

    task automatic test_underflow();
        hold_mode = 1'b1;
        for (int s = 0; s < 5; s++) begin
            load(4'b1010, 6'b100100, 1'b0);
            for (int k = 0; k < 4; k++) begin
                sample();
                tests++;
                if (out_i0 !== 18'sd0 || out_q0 !== 18'sd0 || out_i2 !== 18'sd0) begin
                    fails++;
                    $display("FAIL underflow_out_%0d_%0d: i=%0d q=%0d i2=%0d, want 0",
                             s, k, out_i0, out_q0, out_i2);
                end
            end
            if (s == 2) begin
                tests++;
                if (cnt0 !== 16'd3 || cnt1 !== 2'd3) begin
                    fails++;
                    $display("FAIL underflow_cnt3: cnt=%0d cnt_w2=%0d, want 3 3", cnt0, cnt1);
                end
            end
        end
        tests++;
        if (cnt0 !== 16'd5 || cnt1 !== 2'd3 || cnt2 !== 16'd5) begin
            fails++;
            $display("FAIL underflow_sat: cnt=%0d cnt_w2=%0d cnt6=%0d, want 5 3 5",
                     cnt0, cnt1, cnt2);
        end
    endtask

    task automatic test_async_reset();
        hold_mode = 1'b1;
        load(4'b1001, 6'b000000, 1'b1);
        sample();
        sample();
        #3;
        reset = 1'b0;
        #1;
        tests++;
        if (out_i0 !== 18'sd0 || out_q0 !== 18'sd0 || phase0 !== 4'd0 ||
            cnt0 !== 16'd0 || cnt1 !== 2'd0 || strobe0 !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: i=%0d q=%0d ph=%0d cnt=%0d cnt_w2=%0d stb=%0b, want 0",
                     out_i0, out_q0, phase0, cnt0, cnt1, strobe0);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        hold_mode = 1'b0;
        load(4'b1111, 6'b000000, 1'b1);
        tests++;
        if (out_i0 !== 18'sd0 || phase0 !== 4'd0) begin
            fails++;
            $display("FAIL post_reset_load: i=%0d ph=%0d, want 0 0", out_i0, phase0);
        end
        sample();
        tests++;
        if (out_i0 !== 18'sd16384 || out_q0 !== 18'sd16384 || strobe0 !== 1'b1 ||
            phase0 !== 4'd1) begin
            fails++;
            $display("FAIL post_reset_first: i=%0d q=%0d stb=%0b ph=%0d, want 16384 16384 1 1",
                     out_i0, out_q0, strobe0, phase0);
        end
    endtask

    initial begin
        test_reset();
        test_mapping();
        test_zero_stuff();
        test_hold();
        test_order6();
        test_missing_sym();
        test_underflow();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
